// File: rtl/mmips_stack_pkg.sv
// Shared parameters and FSM encoding for the MMIPS return-address stack
// sequencing controller.
package mmips_stack_pkg;
   localparam int ADDR_W  = 12;
   localparam int DEPTH   = 8;
   localparam int DEPTH_W = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PUSH  = 3'd1,
      TOS   = 3'd2,
      POP   = 3'd3,
      FAULT = 3'd4
   } state_t;
endpackage

// File: rtl/call_stack_ctrl_if.sv
// Request/ack bundle between the main control unit (master) and the
// call stack controller (slave).
interface call_stack_ctrl_if;
   import mmips_stack_pkg::*;

   // Handshake: the master raises call_req or ret_req (call_addr stable) and
   // holds it until the matching ack; acks are combinational and only fire in
   // IDLE, and the transfer happens on the rising edge where req and ack are
   // both high. done/err/ret_valid are one-cycle registered pulses.
   logic              call_req;
   logic [ADDR_W-1:0] call_addr;
   logic              ret_req;
   logic              call_ack;
   logic              ret_ack;
   logic              ready;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] ret_addr;
   logic              ret_valid;

   modport master (
      output call_req, call_addr, ret_req,
      input  call_ack, ret_ack, ready, done, err, ret_addr, ret_valid
   );

   modport slave (
      input  call_req, call_addr, ret_req,
      output call_ack, ret_ack, ready, done, err, ret_addr, ret_valid
   );
endinterface

// File: rtl/call_stack_ctrl.sv
// Sequences push/tos/pop strobes to the hardware return-address stack,
// tracks its depth and blocks overflow/underflow before any stack access.
module call_stack_ctrl
   import mmips_stack_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   call_stack_ctrl_if.slave     bus,
   output logic [DEPTH_W-1:0]   depth,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 push_sig,
   output logic                 pop_sig,
   output logic                 tos_sig,
   output logic [ADDR_W-1:0]    push_data,
   input  logic [ADDR_W-1:0]    stack_out,
   output state_t               fsm_state
);

   state_t            state;
   logic              done_q;
   logic              err_q;
   logic              ret_valid_q;
   logic [ADDR_W-1:0] ret_addr_q;

   // Returns win over calls; a simultaneous call simply stays pending.
   assign bus.ready     = (state == IDLE);
   assign bus.ret_ack   = bus.ready && bus.ret_req;
   assign bus.call_ack  = bus.ready && bus.call_req && !bus.ret_req;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.ret_valid = ret_valid_q;
   assign bus.ret_addr  = ret_addr_q;

   assign push_sig  = (state == PUSH);
   assign tos_sig   = (state == TOS);
   assign pop_sig   = (state == POP);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ret_valid_q <= 1'b0;
         ret_addr_q  <= '0;
         push_data   <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ret_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ret_ack) begin
                  if (depth == '0) begin
                     underflow <= 1'b1;
                     state     <= FAULT;
                  end else begin
                     state <= TOS;
                  end
               end else if (bus.call_ack) begin
                  if (depth == DEPTH_W'(DEPTH)) begin
                     overflow <= 1'b1;
                     state    <= FAULT;
                  end else begin
                     push_data <= bus.call_addr;
                     state     <= PUSH;
                  end
               end
            end
            PUSH: begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
            // Stack presents its top while tos_sig is high; grab it before the pop.
            TOS: begin
               ret_addr_q <= stack_out;
               state      <= POP;
            end
            POP: begin
               done_q      <= 1'b1;
               ret_valid_q <= 1'b1;
               state       <= IDLE;
            end
            FAULT: begin
               done_q <= 1'b1;
               err_q  <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
      end else if (state == PUSH) begin
         depth <= depth + DEPTH_W'(1);
      end else if (state == POP) begin
         depth <= depth - DEPTH_W'(1);
      end
   end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl with a behavioural 8-entry stack.
module tb_call_stack_ctrl;
   import mmips_stack_pkg::*;

   logic              clk;
   logic              rst;
   logic [3:0]        depth;
   logic              overflow;
   logic              underflow;
   logic              push_sig;
   logic              pop_sig;
   logic              tos_sig;
   logic [11:0]       push_data;
   logic [11:0]       stack_out;
   state_t            fsm_state;

   call_stack_ctrl_if bus ();

   call_stack_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .depth     (depth),
      .overflow  (overflow),
      .underflow (underflow),
      .push_sig  (push_sig),
      .pop_sig   (pop_sig),
      .tos_sig   (tos_sig),
      .push_data (push_data),
      .stack_out (stack_out),
      .fsm_state (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural stack (reinitialised with rst)
   logic [11:0] mem [8];
   int          sp;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp <= 0;
      end else begin
         if (push_sig && sp < 8) begin
            mem[sp] <= push_data;
            sp      <= sp + 1;
         end
         if (pop_sig && sp > 0) sp <= sp - 1;
      end
   end
   assign stack_out = (sp > 0) ? mem[sp-1] : 12'h000;

   // scoreboard
   logic [11:0] exp_q [$];
   logic        err_q [$];
   int          total;
   int          bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("strobe_onehot", 32'($countones({push_sig, pop_sig, tos_sig}) <= 1), 1);
         if (bus.done) begin
            if (err_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_err", bus.err, err_q.pop_front());
         end
         if (bus.ret_valid) begin
            if (!bus.done) chk("ret_valid_without_done", 1, 0);
            if (exp_q.size() == 0) chk("unexpected_ret_valid", 1, 0);
            else chk("ret_addr_sb", bus.ret_addr, exp_q.pop_front());
         end
      end
   end

   // driver: one full request, checks strobe timing relative to acceptance
   task automatic run_op(input logic is_ret, input logic [11:0] a,
                         input logic exp_err, input logic [11:0] exp_ret);
      int n;
      int t_done, t_push, t_tos, t_pop, n_push, n_tos, n_pop;
      t_done = 0; t_push = 0; t_tos = 0; t_pop = 0;
      n_push = 0; n_tos = 0; n_pop = 0;
      err_q.push_back(exp_err);
      if (is_ret && !exp_err) exp_q.push_back(exp_ret);
      @(negedge clk);
      if (is_ret) bus.ret_req = 1'b1;
      else begin
         bus.call_req  = 1'b1;
         bus.call_addr = a;
      end
      for (n = 0; n < 20; n++) begin
         #1;
         if (is_ret ? bus.ret_ack : bus.call_ack) break;
         @(negedge clk);
      end
      chk("ack_timeout", 32'(n < 20), 1);
      @(posedge clk);
      #1;
      bus.call_req = 1'b0;
      bus.ret_req  = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (push_sig) begin n_push++; t_push = c; end
         if (tos_sig)  begin n_tos++;  t_tos  = c; end
         if (pop_sig)  begin n_pop++;  t_pop  = c; end
         if (bus.done) begin t_done = c; break; end
      end
      if (exp_err) begin
         chk("fault_done_cycle", t_done, 2);
         chk("fault_no_strobe", n_push + n_tos + n_pop, 0);
      end else if (is_ret) begin
         chk("ret_done_cycle", t_done, 3);
         chk("ret_tos_once", n_tos, 1);
         chk("ret_pop_once", n_pop, 1);
         chk("ret_tos_before_pop", t_pop - t_tos, 1);
         chk("ret_no_push", n_push, 0);
      end else begin
         chk("call_done_cycle", t_done, 2);
         chk("call_push_once", n_push, 1);
         chk("call_push_cycle", t_push, 1);
         chk("call_no_tos_pop", n_tos + n_pop, 0);
      end
   endtask

   typedef struct {
      logic        is_ret;
      logic [11:0] addr;
      logic        exp_err;
      logic [3:0]  exp_depth;
      logic        exp_ovf;
      logic        exp_udf;
      logic [11:0] exp_ret;
   } vec_t;

   vec_t        vecs [18];
   logic [11:0] ref_q [$];
   logic [11:0] a;
   logic [11:0] e;

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 8; i++)
         vecs[i] = '{1'b0, 12'(i + 1), 1'b0, 4'(i + 1), 1'b0, 1'b0, 12'h123};
      vecs[8] = '{1'b0, 12'h1FF, 1'b1, 4'd8, 1'b1, 1'b0, 12'h123};
      for (int i = 0; i < 8; i++)
         vecs[9 + i] = '{1'b1, 12'h000, 1'b0, 4'(7 - i), 1'b1, 1'b0, 12'(8 - i)};
      vecs[17] = '{1'b1, 12'h000, 1'b1, 4'd0, 1'b1, 1'b1, 12'h001};

      rst = 1'b1;
      bus.call_req  = 1'b0;
      bus.ret_req   = 1'b0;
      bus.call_addr = 12'h000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_ready", bus.ready, 1);
      chk("rst_state", fsm_state, IDLE);
      chk("rst_depth", depth, 0);
      chk("rst_strobes", {push_sig, pop_sig, tos_sig}, 0);
      chk("rst_done_err_rv", {bus.done, bus.err, bus.ret_valid}, 0);
      chk("rst_flags", {overflow, underflow}, 0);
      chk("rst_ret_addr", bus.ret_addr, 0);
      chk("rst_push_data", push_data, 0);

      // hand sequence: single call 0x123 with cycle-level checks
      err_q.push_back(1'b0);
      bus.call_req  = 1'b1;
      bus.call_addr = 12'h123;
      #1;
      chk("c123_call_ack", bus.call_ack, 1);
      chk("c123_ret_ack", bus.ret_ack, 0);
      @(posedge clk);
      #1;
      bus.call_req = 1'b0;
      @(negedge clk);
      chk("c123_push_sig", push_sig, 1);
      chk("c123_state", fsm_state, PUSH);
      chk("c123_ready_low", bus.ready, 0);
      chk("c123_push_data", push_data, 12'h123);
      chk("c123_depth_before", depth, 0);
      chk("c123_done_early", bus.done, 0);
      @(negedge clk);
      chk("c123_push_off", push_sig, 0);
      chk("c123_done", bus.done, 1);
      chk("c123_err", bus.err, 0);
      chk("c123_depth", depth, 1);
      chk("c123_ready", bus.ready, 1);
      run_op(1'b1, 12'h000, 1'b0, 12'h123);
      chk("r123_ret_addr", bus.ret_addr, 12'h123);
      chk("r123_depth", depth, 0);

      // table: fill to 8, overflow, drain, underflow
      for (int i = 0; i < 18; i++) begin
         run_op(vecs[i].is_ret, vecs[i].addr, vecs[i].exp_err, vecs[i].exp_ret);
         chk($sformatf("vec%0d_depth", i), depth, vecs[i].exp_depth);
         chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
         chk($sformatf("vec%0d_udf", i), underflow, vecs[i].exp_udf);
         chk($sformatf("vec%0d_ret_addr", i), bus.ret_addr, vecs[i].exp_ret);
      end

      // random push/pop round; flags must stay sticky
      for (int i = 0; i < 4; i++) begin
         a = 12'($urandom_range(0, 4095));
         ref_q.push_back(a);
         run_op(1'b0, a, 1'b0, 12'h000);
         chk("rnd_call_depth", depth, 32'(i + 1));
      end
      for (int i = 0; i < 4; i++) begin
         e = ref_q.pop_back();
         run_op(1'b1, 12'h000, 1'b0, e);
         chk("rnd_ret_addr", bus.ret_addr, e);
      end
      chk("rnd_depth_end", depth, 0);
      chk("sticky_flags", {overflow, underflow}, 2'b11);

      // simultaneous requests at depth 2
      run_op(1'b0, 12'h011, 1'b0, 12'h000);
      run_op(1'b0, 12'h022, 1'b0, 12'h000);
      err_q.push_back(1'b0);
      err_q.push_back(1'b0);
      exp_q.push_back(12'h022);
      @(negedge clk);
      bus.call_req  = 1'b1;
      bus.call_addr = 12'h0AA;
      bus.ret_req   = 1'b1;
      #1;
      chk("both_ret_ack", bus.ret_ack, 1);
      chk("both_call_ack", bus.call_ack, 0);
      @(posedge clk);
      #1;
      bus.ret_req = 1'b0;
      @(negedge clk);
      chk("both_tos", tos_sig, 1);
      chk("both_call_ack_busy", bus.call_ack, 0);
      @(negedge clk);
      chk("both_pop", pop_sig, 1);
      @(negedge clk);
      chk("both_done", bus.done, 1);
      chk("both_call_ack_on_done", bus.call_ack, 1);
      chk("both_ret_addr", bus.ret_addr, 12'h022);
      @(posedge clk);
      #1;
      bus.call_req = 1'b0;
      @(negedge clk);
      chk("both_push", push_sig, 1);
      chk("both_push_data", push_data, 12'h0AA);
      @(negedge clk);
      chk("both_call_done", bus.done, 1);
      chk("both_depth", depth, 2);
      chk("both_ret_addr_held", bus.ret_addr, 12'h022);

      // reset in the middle of TOS
      @(negedge clk);
      bus.ret_req = 1'b1;
      #1;
      chk("rtos_ret_ack", bus.ret_ack, 1);
      @(posedge clk);
      #1;
      bus.ret_req = 1'b0;
      @(negedge clk);
      chk("rtos_tos", tos_sig, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("rtos_strobes", {push_sig, pop_sig, tos_sig}, 0);
      chk("rtos_state", fsm_state, IDLE);
      chk("rtos_depth", depth, 0);
      chk("rtos_flags", {overflow, underflow}, 0);
      chk("rtos_ready", bus.ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rtos_after_ready", bus.ready, 1);
      chk("rtos_after_done", bus.done, 0);
      chk("rtos_after_depth", depth, 0);

      chk("exp_q_empty", exp_q.size(), 0);
      chk("err_q_empty", err_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
